// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: tracks make/break/extended sequences, keeps a held bitmap for the game keys
// and emits press/release pulses. Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat presses.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [6:0] key_held,
  output logic [6:0] key_press,
  output logic [6:0] key_release,
  output logic       start,
  output logic       move_up,
  output logic       seq_error
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int unsigned NKEYS   = 7;

  localparam logic [7:0] C_BRK = 8'hF0;
  localparam logic [7:0] C_EXT = 8'hE0;
  localparam logic [7:0] C_UP  = 8'h75;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [NKEYS-1:0] r_held;
  logic [NKEYS-1:0] r_press;
  logic [NKEYS-1:0] r_release;
  logic             r_start, r_move_up, r_seq_error;

  logic [NKEYS-1:0] w_map;
  logic [NKEYS-1:0] w_make, w_brk, w_press, w_rel, w_held_nxt;
  logic             w_err, w_timeout;

  // Non-extended code to key one-hot; UP only exists as an extended code.
  always_comb begin
    w_map = '0;
    case (scan_code)
      8'h1D:   w_map = 7'b000_0001;
      8'h1C:   w_map = 7'b000_0010;
      8'h1B:   w_map = 7'b000_0100;
      8'h23:   w_map = 7'b000_1000;
      8'h4D:   w_map = 7'b001_0000;
      8'h29:   w_map = 7'b010_0000;
      default: w_map = '0;
    endcase
  end

  // Sequence FSM: next state plus make/break/error events for this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = '0;
    w_brk       = '0;
    w_err       = 1'b0;
    w_timeout   = (r_state != S_IDLE) && (r_cnt == CNT_MAX) && !scan_valid;
    if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_code == C_BRK)      w_state_nxt = S_BRK;
          else if (scan_code == C_EXT) w_state_nxt = S_EXT;
          else                         w_make      = w_map;
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          if (scan_code == C_BRK || scan_code == C_EXT) w_err = 1'b1;
          else                                          w_brk = w_map;
        end
        S_EXT: begin
          if (scan_code == C_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (scan_code == C_UP)       w_make[6] = 1'b1;
            else if (scan_code == C_EXT) w_err     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          if (scan_code == C_UP)                             w_brk[6] = 1'b1;
          else if (scan_code == C_EXT || scan_code == C_BRK) w_err    = 1'b1;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end
  end

  // Press/release qualification against the current held bitmap.
  always_comb begin
`ifdef PS2_TYPEMATIC_FILTER_EN
    w_press = w_make & ~r_held;
`else
    w_press = w_make;
`endif
    w_rel      = w_brk & r_held;
    w_held_nxt = (r_held | w_make) & ~w_rel;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix timeout counter, saturating at TIMEOUT_CYCLES.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (scan_valid || r_state == S_IDLE || w_timeout) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_held      <= '0;
      r_press     <= '0;
      r_release   <= '0;
      r_start     <= 1'b0;
      r_move_up   <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_held      <= w_held_nxt;
      r_press     <= w_press;
      r_release   <= w_rel;
      r_start     <= w_press[4];
      r_move_up   <= w_held_nxt[5] | w_held_nxt[6];
      r_seq_error <= w_err;
    end
  end

  assign key_held    = r_held;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign start       = r_start;
  assign move_up     = r_move_up;
  assign seq_error   = r_seq_error;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios plus randomized byte streams against a
// prefix-queue reference model. Honors PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_key_tracker;

  localparam int unsigned TMO = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [6:0] key_held, key_press, key_release;
  logic       start, move_up, seq_error;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .key_held   (key_held),
    .key_press  (key_press),
    .key_release(key_release),
    .start      (start),
    .move_up    (move_up),
    .seq_error  (seq_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [23:0] w_obs;
  assign w_obs = {key_held, key_press, key_release, start, move_up, seq_error};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending prefix bytes, idle cycles since last byte, held bitmap.
  logic [7:0]  m_pend[$];
  int          m_idle;
  logic [6:0]  m_held;
  logic [23:0] exp_vec;

  function automatic int key_of(input logic [7:0] c);
    logic [7:0] codes [6];
    codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h4D, 8'h29};
    for (int i = 0; i < 6; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_step(input logic rst_n, input logic v, input logic [7:0] c);
    logic [6:0] pr;
    logic [6:0] rl;
    logic       er;
    bit         ext, brk;
    int         k;
    pr = '0; rl = '0; er = 1'b0;
    if (!rst_n) begin
      m_held = '0; m_pend.delete(); m_idle = 0; exp_vec = '0;
      return;
    end
    k = -1;
    if (v) begin
      m_idle = 0;
      if (m_pend.size() == 0) begin
        if (c == 8'hF0 || c == 8'hE0) m_pend.push_back(c);
        else k = key_of(c);
        if (k >= 0) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!m_held[k]) pr[k] = 1'b1;
`else
          pr[k] = 1'b1;
`endif
          m_held[k] = 1'b1;
        end
      end else if (m_pend.size() == 1 && m_pend[0] == 8'hE0 && c == 8'hF0) begin
        m_pend.push_back(c);
      end else begin
        ext = (m_pend[0] == 8'hE0);
        brk = (m_pend[m_pend.size()-1] == 8'hF0);
        m_pend.delete();
        if (c == 8'hE0 || (c == 8'hF0 && brk)) er = 1'b1;
        else if (ext && c == 8'h75) begin
          if (brk) begin
            if (m_held[6]) begin rl[6] = 1'b1; m_held[6] = 1'b0; end
          end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_held[6]) pr[6] = 1'b1;
`else
            pr[6] = 1'b1;
`endif
            m_held[6] = 1'b1;
          end
        end else if (!ext) begin
          k = key_of(c);
          if (k >= 0 && m_held[k]) begin rl[k] = 1'b1; m_held[k] = 1'b0; end
        end
      end
    end else if (m_pend.size() != 0) begin
      // Counter sits at TMO after TMO idle cycles; the next idle cycle abandons the prefix.
      m_idle++;
      if (m_idle > int'(TMO)) begin
        er = 1'b1; m_pend.delete(); m_idle = 0;
      end
    end
    exp_vec = {m_held, pr, rl, pr[4], m_held[5] | m_held[6], er};
  endtask

  // Apply one cycle of input, then advance the model to match the post-edge outputs.
  task automatic drive(input logic rst_n, input logic v, input logic [7:0] c);
    @(negedge CLOCK_50);
    reset = rst_n; scan_valid = v; scan_code = c;
    @(posedge CLOCK_50);
    #1;
    model_step(rst_n, v, c);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'h29);
    drive(1'b0, 1'b0, 8'h00);
    n_vec++;
    if (w_obs !== 24'h0) begin
      n_err++; $display("FAIL reset_state got=%h want=%h", w_obs, 24'h0);
    end
  endtask

  task automatic test_space();
    logic [7:0] seq [3];
    seq = '{8'h29, 8'hF0, 8'h29};
    drive(1'b1, 1'b1, seq[0]);
    n_vec++;
    if (key_held !== 7'b0100000 || move_up !== 1'b1 || key_press !== 7'b0100000) begin
      n_err++; $display("FAIL space_make held=%b up=%b press=%b want held=0100000 up=1 press=0100000",
                        key_held, move_up, key_press);
    end
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, 1'b1, seq[i]);
      n_vec++;
      if (w_obs !== exp_vec) begin
        n_err++; $display("FAIL space_seq[%0d] got=%h want=%h", i, w_obs, exp_vec);
      end
    end
    n_vec++;
    if (key_held !== 7'b0 || move_up !== 1'b0 || key_release !== 7'b0100000) begin
      n_err++; $display("FAIL space_break held=%b up=%b rel=%b want held=0 up=0 rel=0100000",
                        key_held, move_up, key_release);
    end
  endtask

  task automatic test_up();
    logic [7:0] seq [6];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, seq[i]);
      n_vec++;
      if (w_obs !== exp_vec) begin
        n_err++; $display("FAIL up_seq[%0d] got=%h want=%h", i, w_obs, exp_vec);
      end
      if (i == 1) begin
        n_vec++;
        if (key_held[6] !== 1'b1 || move_up !== 1'b1) begin
          n_err++; $display("FAIL up_make held6=%b up=%b want 1 1", key_held[6], move_up);
        end
      end
    end
    n_vec++;
    if (key_held !== 7'b0 || key_press !== 7'b0) begin
      n_err++; $display("FAIL up_lone75 held=%b press=%b want 0 0", key_held, key_press);
    end
  endtask

  task automatic test_typematic();
    int pulses;
    int want;
    pulses = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    want = 1;
`else
    want = 3;
`endif
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'h4D);
      if (start === 1'b1) pulses++;
      n_vec++;
      if (w_obs !== exp_vec) begin
        n_err++; $display("FAIL typematic_make[%0d] got=%h want=%h", i, w_obs, exp_vec);
      end
      drive(1'b1, 1'b0, 8'h00);
      if (start === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== want) begin
      n_err++; $display("FAIL typematic_start_count got=%0d want=%0d", pulses, want);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < int'(TMO); i++) begin
      drive(1'b1, 1'b0, 8'h00);
      if (seq_error !== 1'b0) early++;
    end
    n_vec++;
    if (early !== 0) begin
      n_err++; $display("FAIL timeout_early got=%0d want=0", early);
    end
    drive(1'b1, 1'b0, 8'h00);
    n_vec++;
    if (seq_error !== 1'b1) begin
      n_err++; $display("FAIL timeout_fire got=%b want=1", seq_error);
    end
    drive(1'b1, 1'b1, 8'h1C);
    n_vec++;
    if (key_held !== 7'b0000010 || key_release !== 7'b0 || seq_error !== 1'b0) begin
      n_err++; $display("FAIL timeout_then_make held=%b rel=%b err=%b want 0000010 0 0",
                        key_held, key_release, seq_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [3];
    seq = '{8'h1D, 8'h1C, 8'h23};
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, seq[i]);
    n_vec++;
    if (key_held !== 7'b0001011) begin
      n_err++; $display("FAIL hold_wad got=%b want=0001011", key_held);
    end
    drive(1'b1, 1'b1, 8'hF0);
    drive(1'b0, 1'b1, 8'h1D);
    n_vec++;
    if (w_obs !== 24'h0) begin
      n_err++; $display("FAIL reset_mid got=%h want=%h", w_obs, 24'h0);
    end
    drive(1'b1, 1'b1, 8'h1D);
    n_vec++;
    if (key_held !== 7'b0000001 || key_press !== 7'b0000001 || key_release !== 7'b0) begin
      n_err++; $display("FAIL reset_mid_make held=%b press=%b rel=%b want 0000001 0000001 0",
                        key_held, key_press, key_release);
    end
  endtask

  task automatic test_errors();
    drive(1'b1, 1'b1, 8'hF0);
    drive(1'b1, 1'b1, 8'hF0);
    n_vec++;
    if (seq_error !== 1'b1 || w_obs !== exp_vec) begin
      n_err++; $display("FAIL brk_brk got=%h want=%h", w_obs, exp_vec);
    end
    drive(1'b1, 1'b1, 8'hF0);
    drive(1'b1, 1'b1, 8'h1B);
    n_vec++;
    if (key_release !== 7'b0 || seq_error !== 1'b0) begin
      n_err++; $display("FAIL brk_not_held rel=%b err=%b want 0 0", key_release, seq_error);
    end
    // W is held here; its break lands exactly when the counter saturates.
    drive(1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < int'(TMO); i++) drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h1D);
    n_vec++;
    if (seq_error !== 1'b0 || key_release !== 7'b0000001 || key_held[0] !== 1'b0) begin
      n_err++; $display("FAIL timeout_race err=%b rel=%b held0=%b want 0 0000001 0",
                        seq_error, key_release, key_held[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [14];
    logic [7:0] c;
    logic       v;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h4D, 8'h29, 8'h75,
             8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hE1};
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < int'($urandom_range(95, 105)); j++) begin
          drive(1'b1, 1'b0, 8'h00);
          n_vec++;
          if (w_obs !== exp_vec) begin
            n_err++; $display("FAIL rand_idle[%0d.%0d] got=%h want=%h", i, j, w_obs, exp_vec);
          end
        end
      end
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      drive(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, v, c);
      n_vec++;
      if (w_obs !== exp_vec) begin
        n_err++; $display("FAIL rand[%0d] v=%b c=%h got=%h want=%h", i, v, c, w_obs, exp_vec);
      end
    end
  endtask

  initial begin
    m_held = '0; m_idle = 0; exp_vec = '0;
    test_reset();
    test_space();
    test_up();
    test_typematic();
    test_timeout();
    test_reset_mid();
    test_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
